// File: rtl/handshake_receiver_if.sv
// Board-edge link between the sender board and handshake_receiver.
// 4-phase REQ/ACK chunk bus plus the reassembled datagram outputs.
interface handshake_receiver_if #(
   parameter int N       = 16,
   parameter int CHUNK_W = 6
);
   logic               wire_req;
   logic [CHUNK_W-1:0] wire_data_deliver;
   logic               reg_ack;
   logic [N-1:0]       wire_data_out;
   logic               reg_valid;
   logic               frame_err;
   logic               busy;

   modport master (
      output wire_req, wire_data_deliver,
      input  reg_ack, wire_data_out, reg_valid, frame_err, busy
   );

   modport slave (
      input  wire_req, wire_data_deliver,
      output reg_ack, wire_data_out, reg_valid, frame_err, busy
   );
endinterface

// File: rtl/handshake_receiver.sv
// Receive side of the 4-phase REQ/ACK link: reassembles LS-chunk-first
// chunks into an n-bit datagram, dropping stalled partial frames.
module handshake_receiver #(
   parameter int n       = 16,
   parameter int CHUNK_W = 6,
   parameter int TIMEOUT = 1023
) (
   input logic                 clk,
   input logic                 rst,
   handshake_receiver_if.slave link
);
   localparam int NCHUNK = (n + CHUNK_W - 1) / CHUNK_W;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(NCHUNK - 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT - 1);

   typedef enum logic {WAIT_REQ, WAIT_REL} state_t;

   state_t           state, state_nxt;
   logic             req_m, req_s;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [n-1:0]     shadow, shadow_nxt, cap;
   logic [n-1:0]     dout, dout_nxt;
   logic             ack, ack_nxt;
   logic             valid, valid_nxt;
   logic             ferr, ferr_nxt;
   logic             busy, busy_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_m  <= 1'b0;
         req_s  <= 1'b0;
         state  <= WAIT_REQ;
         idx    <= '0;
         cnt    <= '0;
         shadow <= '0;
         dout   <= '0;
         ack    <= 1'b0;
         valid  <= 1'b0;
         ferr   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         req_m  <= link.wire_req;
         req_s  <= req_m;
         state  <= state_nxt;
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
         shadow <= shadow_nxt;
         dout   <= dout_nxt;
         ack    <= ack_nxt;
         valid  <= valid_nxt;
         ferr   <= ferr_nxt;
         busy   <= busy_nxt;
      end
   end

   // Bits beyond n in the last chunk simply have no destination.
   always_comb begin
      cap = shadow;
      for (int b = 0; b < n; b++) begin
         if (b / CHUNK_W == int'(idx))
            cap[b] = link.wire_data_deliver[b % CHUNK_W];
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      cnt_nxt    = cnt;
      shadow_nxt = shadow;
      dout_nxt   = dout;
      ack_nxt    = ack;
      valid_nxt  = 1'b0;
      ferr_nxt   = 1'b0;
      unique case (state)
         WAIT_REQ: begin
            if (req_s) begin
               shadow_nxt = cap;
               ack_nxt    = 1'b1;
               cnt_nxt    = '0;
               state_nxt  = WAIT_REL;
               if (idx == LAST) begin
                  dout_nxt  = cap;
                  valid_nxt = 1'b1;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end else if (idx != '0) begin
               if (cnt == CNT_TOP) begin
                  idx_nxt  = '0;
                  cnt_nxt  = '0;
                  ferr_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         WAIT_REL: begin
            if (!req_s) begin
               ack_nxt   = 1'b0;
               state_nxt = WAIT_REQ;
            end
         end
         default: state_nxt = WAIT_REQ;
      endcase
      busy_nxt = (idx_nxt != '0);
   end

   assign link.reg_ack       = ack;
   assign link.wire_data_out = dout;
   assign link.reg_valid     = valid;
   assign link.frame_err     = ferr;
   assign link.busy          = busy;
endmodule

// File: tb/tb_handshake_receiver.sv
// Randomized scoreboard bench for handshake_receiver:
// sender tasks push expected datagrams, a monitor pops on reg_valid.
module tb_handshake_receiver;
   localparam int N   = 16;
   localparam int CW  = 6;
   localparam int TO  = 20;
   localparam int NCH = (N + CW - 1) / CW;
   localparam int VB  = N - (NCH - 1) * CW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   handshake_receiver_if #(.N(N), .CHUNK_W(CW)) link ();

   handshake_receiver #(.n(N), .CHUNK_W(CW), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link.slave)
   );

   int           checks = 0;
   int           fails = 0;
   int           ferr_seen = 0;
   int           ferr_exp = 0;
   logic [N-1:0] expq[$];
   logic [N-1:0] last_word = '0;
   bit           prev_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (link.reg_valid) begin
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
            check("valid_expected", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0)
               check("data_out", 32'(link.wire_data_out),
                     32'(expq.pop_front()));
         end
         if (link.frame_err) ferr_seen++;
      end
      prev_valid = link.reg_valid;
   end

   task automatic wait_ack(input logic lvl, output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (link.reg_ack !== lvl && edges < 12);
   endtask

   task automatic raise(input logic [CW-1:0] c, input bit last,
                        input logic [N-1:0] exp_out);
      int e;
      link.wire_data_deliver = c;
      link.wire_req = 1'b1;
      wait_ack(1'b1, e);
      check("ack_rise_latency", 32'(e), 32'd3);
      check("valid_with_ack", 32'(link.reg_valid), 32'(last));
      check("busy_after_capture", 32'(link.busy), 32'(!last));
      check("data_out_held", 32'(link.wire_data_out), 32'(exp_out));
   endtask

   task automatic release_req();
      int e;
      link.wire_req = 1'b0;
      wait_ack(1'b0, e);
      check("ack_fall_latency", 32'(e), 32'd3);
   endtask

   task automatic send_frame(input logic [N-1:0] w, input logic [CW-1:0] top,
                             input int hold);
      logic [N-1:0]  sh;
      logic [CW-1:0] c;
      logic [CW-1:0] hi;
      int            drops;
      hi = ~CW'((1 << VB) - 1);
      for (int i = 0; i < NCH; i++) begin
         sh = w >> (CW * i);
         c  = sh[CW-1:0];
         if (i == NCH - 1) begin
            c = c | (top & hi);
            expq.push_back(w);
            raise(c, 1'b1, w);
            last_word = w;
            if (hold > 0) begin
               drops = 0;
               repeat (hold) begin
                  @(posedge clk);
                  #1;
                  if (link.reg_ack !== 1'b1) drops++;
               end
               check("ack_held", 32'(drops), 32'd0);
            end
         end else begin
            raise(c, 1'b0, last_word);
         end
         release_req();
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      link.wire_req = 1'b0;
      link.wire_data_deliver = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(link.reg_ack), 32'd0);
      check("rst_valid", 32'(link.reg_valid), 32'd0);
      check("rst_ferr", 32'(link.frame_err), 32'd0);
      check("rst_busy", 32'(link.busy), 32'd0);
      check("rst_data_out", 32'(link.wire_data_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      send_frame(16'hBEEF, 6'h00, 0);
      send_frame(16'hBEEF, 6'h30, 0);
      send_frame(16'h5A5A, 6'h3F, 50);

      // Partial frame left to stall until it is dropped
      raise(6'h15, 1'b0, last_word);
      release_req();
      e = 0;
      do begin
         @(posedge clk);
         #1;
         e++;
      end while (link.frame_err !== 1'b1 && e < 2 * TO);
      ferr_exp++;
      check("timeout_latency", 32'(e), 32'(TO));
      check("timeout_busy", 32'(link.busy), 32'd0);
      check("timeout_data_out", 32'(link.wire_data_out), 32'(last_word));
      @(posedge clk);
      #1;
      check("timeout_ferr_single", 32'(link.frame_err), 32'd0);
      send_frame(16'h1234, 6'h00, 0);

      // Asynchronous reset while ACK is high on the second chunk
      raise(6'h2F, 1'b0, last_word);
      release_req();
      raise(6'h3B, 1'b0, last_word);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ack", 32'(link.reg_ack), 32'd0);
      check("arst_busy", 32'(link.busy), 32'd0);
      check("arst_valid", 32'(link.reg_valid), 32'd0);
      check("arst_data_out", 32'(link.wire_data_out), 32'd0);
      last_word = '0;
      link.wire_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send_frame(16'hBEEF, 6'h00, 0);

      send_frame(16'hBEEF, 6'h00, 0);
      send_frame(16'h0000, 6'h3F, 0);

      for (int k = 0; k < 12; k++)
         send_frame(N'($urandom), CW'($urandom), 0);

      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", 32'(expq.size()), 32'd0);
      check("frame_err_count", 32'(ferr_seen), 32'(ferr_exp));
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end
endmodule
